// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the serial shift sequencer.
// The state encoding is fixed so that probes can decode it directly.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_MSB = 1'b0;
    localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/shreg_core.sv
// Datapath register for the shift sequencer: parallel load, 1-bit shift with 0 fill.
// A load takes priority over a shift; otherwise the register holds its value.
module shreg_core
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh_en,
    input  logic             dir,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end else if (sh_en) begin
            if (dir == DIR_LSB) begin
                q <= q >> 1;
            end else begin
                q <= q << 1;
            end
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load/shift/count sequencer: takes a parallel word, streams it out one bit per beat.
// Optional SHIFT_DIR_SEL_EN adds a per-word shift direction input (in_dir).
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
`ifdef SHIFT_DIR_SEL_EN
    input  logic             in_dir,
`endif
    output logic             so_valid,
    input  logic             so_ready,
    output logic             so_bit,
    output logic [WIDTH-1:0] po,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and the sender holds its data
    // stable until the transfer completes.

    // Current state is kept in a named register so probes can bind to it.
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic             dir;
    logic             ld;
    logic             sh_en;

`ifdef SHIFT_DIR_SEL_EN
    logic dir_q;
    assign dir = dir_q;
`else
    assign dir = DIR_MSB;
`endif

    assign in_ready = (state == IDLE);
    assign so_valid = (state == SHIFT);
    assign busy     = (state == SHIFT) || (state == DONE);
    assign done     = (state == DONE);
    assign ld       = in_valid && in_ready;
    assign sh_en    = so_valid && so_ready;
    assign po       = q;

    always_comb begin
        so_bit = 1'b0;
        if (state == SHIFT) begin
            so_bit = (dir == DIR_LSB) ? q[0] : q[WIDTH-1];
        end
    end

    // cnt counts accepted beats of the current word and is cleared on the
    // final beat, so it never passes WIDTH-1 even for power-of-two widths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
`ifdef SHIFT_DIR_SEL_EN
            dir_q <= DIR_MSB;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ld) begin
                        state <= SHIFT;
                        cnt   <= '0;
`ifdef SHIFT_DIR_SEL_EN
                        dir_q <= in_dir;
`endif
                    end
                end
                SHIFT: begin
                    if (sh_en) begin
                        if (cnt == LAST_CNT) begin
                            state <= DONE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    shreg_core #(
        .WIDTH(WIDTH)
    ) u_shreg (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .sh_en(sh_en),
        .dir  (dir),
        .d    (in_data),
        .q    (q)
    );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a word/beat-count model and a serial-bit scoreboard.
module tb_shift_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         in_dir = 1'b0;
    logic         so_valid;
    logic         so_ready = 1'b0;
    logic         so_bit;
    logic [W-1:0] po;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [0:0] exp_q[$];

    // Model: phase 0 idle, 1 streaming, 2 done pulse; word and beats taken.
    int           m_phase = 0;
    int           m_beats = 0;
    logic [W-1:0] m_word  = '0;
    logic         m_dir   = 1'b0;

    shift_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data (in_data),
`ifdef SHIFT_DIR_SEL_EN
        .in_dir  (in_dir),
`endif
        .so_valid(so_valid),
        .so_ready(so_ready),
        .so_bit  (so_bit),
        .po      (po),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model_po();
        if (m_dir) return m_word >> m_beats;
        return m_word << m_beats;
    endfunction

    // Monitor/model: compare at the falling edge, then advance to the next edge.
    always @(negedge clk) begin
        logic [W-1:0] epo;
        logic [0:0]   bit_exp;
        if (rst) begin
            m_phase = 0;
            m_beats = 0;
            m_word  = '0;
            m_dir   = 1'b0;
            exp_q.delete();
        end
        epo = model_po();
        check("in_ready", 32'(in_ready), 32'(m_phase == 0));
        check("so_valid", 32'(so_valid), 32'(m_phase == 1));
        check("busy",     32'(busy),     32'(m_phase != 0));
        check("done",     32'(done),     32'(m_phase == 2));
        check("po",       32'(po),       32'(epo));
        check("so_bit",   32'(so_bit),   (m_phase == 1) ? 32'(m_dir ? epo[0] : epo[W-1]) : 32'd0);
        if (!rst) begin
            if (so_valid && so_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra_beat", 32'd1, 32'd0);
                end else begin
                    bit_exp = exp_q.pop_front();
                    check("sb_bit", 32'(so_bit), 32'(bit_exp));
                end
            end
            case (m_phase)
                0: if (in_valid) begin
                    m_word  = in_data;
`ifdef SHIFT_DIR_SEL_EN
                    m_dir   = in_dir;
`else
                    m_dir   = 1'b0;
`endif
                    m_beats = 0;
                    m_phase = 1;
                    for (int i = 0; i < W; i++)
                        exp_q.push_back(m_dir ? in_data[i] : in_data[W-1-i]);
                end
                1: if (so_ready) begin
                    m_beats++;
                    if (m_beats == W) m_phase = 2;
                end
                default: begin
                    m_phase = 0;
                    m_dir   = 1'b0;
                    m_word  = '0;
                    m_beats = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_data  = W'($urandom());
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic send_stream(input logic [W-1:0] d, input logic dir, input int n_ready_cycles);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        so_ready = 1'b1;
        tick();
        idle_inputs();
        repeat (n_ready_cycles) tick();
    endtask

    initial begin
        int cyc;
        int sent;
        logic pending;
        logic acc;
        logic [6:0] bp;

        // Reset then idle.
        do_reset(2);
        tick();

        // Single word, so_ready high throughout.
        send_stream(4'b1011, 1'b0, W + 3);

        // Back-pressure pattern 1,0,0,1,0,1,1 during the stream.
        bp = 7'b1001011;
        in_valid = 1'b1;
        in_data  = 4'b1001;
        tick();
        idle_inputs();
        for (int i = 6; i >= 0; i--) begin
            so_ready = bp[i];
            tick();
        end
        so_ready = 1'b0;
        repeat (3) tick();

        // Back-to-back: valid held; second word waits for in_ready.
        so_ready = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'b0001;
        tick();
        in_data  = 4'b1111;
        repeat (W + 2) tick();
        idle_inputs();
        repeat (W + 3) tick();

        // Reset mid-word after two bits, then a clean word.
        in_valid = 1'b1;
        in_data  = 4'b0101;
        tick();
        idle_inputs();
        repeat (2) tick();
        rst = 1'b1;
        #2;
        check("rst_async_po", 32'(po), 32'd0);
        check("rst_async_valid", 32'(so_valid), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_stream(4'b1111, 1'b0, W + 3);

`ifdef SHIFT_DIR_SEL_EN
        send_stream(4'b0001, 1'b1, W + 3);
        send_stream(4'b0001, 1'b0, W + 3);
`endif

        // Randomized traffic with producer hold semantics and random back-pressure.
        pending = 1'b0;
        sent = 0;
        cyc = 0;
        while ((sent < 25 || pending || busy) && cyc < 3000) begin
            if (!pending && sent < 25 && $urandom_range(0, 2) != 0) begin
                pending = 1'b1;
                in_data = W'($urandom());
`ifdef SHIFT_DIR_SEL_EN
                in_dir  = 1'($urandom_range(0, 1));
`endif
                sent++;
            end else if (!pending) begin
                in_data = W'($urandom());
            end
            in_valid = pending;
            so_ready = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            tick();
            if (acc) pending = 1'b0;
            cyc++;
        end
        check("rand_timeout", 32'(cyc < 3000), 32'd1);
        idle_inputs();
        so_ready = 1'b1;
        repeat (W + 3) tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
